// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//
// Programmable down-counting timer. A load captures a start value into both
// the live count and a reload register. While running, the count drops by one
// per clock. When the count first reads zero, a one-cycle terminal-count
// strobe is raised. In one-shot mode the timer then parks in DONE. In
// auto-reload mode it restarts from the reload value, which gives a period of
// reload+1 cycles.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous, active-high reset
//   i_load        in   1      capture i_load_val into reload register and count
//   i_load_val    in   WIDTH  value captured on load
//   i_start       in   1      begin / resume counting
//   i_stop        in   1      pause counting (only acts while running)
//   i_auto_reload in   1      1 = periodic, 0 = one-shot
//   o_count       out  WIDTH  current count (registered)
//   o_busy        out  1      high while running
//   o_tc          out  1      one-cycle terminal-count pulse (registered)
//   o_done        out  1      high while a one-shot has expired
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_tc,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    // Decode helpers on registered state only, so no input reaches an output
    // through combinational logic.
    logic w_count_zero;
    logic w_count_one;
    logic w_reload_zero;

    assign w_count_zero  = (r_count == '0);
    assign w_count_one   = (r_count == WIDTH'(1));
    assign w_reload_zero = (r_reload == '0);

    // Single-process FSM. r_busy / r_done are registered copies of the state
    // decode and are written in every branch that changes r_state, which keeps
    // them exactly in step with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // The strobe is strictly one cycle unless a branch below re-asserts it.
            r_tc <= 1'b0;

            if (i_load) begin
                // A load overrides everything else on this edge, including start/stop.
                r_reload <= i_load_val;
                r_count  <= i_load_val;
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        // Stop outranks start but has nothing to pause here, so the
                        // edge is simply consumed.
                        if (!i_stop && i_start) begin
                            if (!w_count_zero) begin
                                // The count is not decremented on the starting edge.
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                // Starting from zero expires immediately.
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_tc    <= 1'b1;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (i_stop) begin
                            // Pause without decrementing. A pending count==1 keeps
                            // its strobe for when counting resumes.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b0;
                        end else if (w_count_one) begin
                            // Zero crossing. The strobe lines up with the cycle in
                            // which the count reads zero.
                            r_count <= '0;
                            r_tc    <= 1'b1;
                            if (!i_auto_reload) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (w_count_zero) begin
                            // Only reachable in auto-reload mode, one cycle after the
                            // crossing. A zero reload keeps the strobe high every
                            // cycle.
                            r_count <= r_reload;
                            if (w_reload_zero) begin
                                r_tc <= 1'b1;
                            end
                        end else begin
                            // Guarded by the two branches above, so this never
                            // wraps below zero.
                            r_count <= r_count - WIDTH'(1);
                        end
                    end

                    ST_DONE: begin
                        if (!i_stop && i_start) begin
                            r_count <= r_reload;
                            if (!w_reload_zero) begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                // Restarting a zero-length timer re-expires at once.
                                r_tc <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        // Unused encoding: recover to a safe idle state.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_tc    = r_tc;
    assign o_done  = r_done;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic             i_start;
    logic             i_stop;
    logic             i_auto_reload;
    logic [WIDTH-1:0] o_count;
    logic             o_busy;
    logic             o_tc;
    logic             o_done;

    int n_total;
    int n_bad;

    down_timer #(.WIDTH(WIDTH)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_load        (i_load),
        .i_load_val    (i_load_val),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_auto_reload (i_auto_reload),
        .o_count       (o_count),
        .o_busy        (o_busy),
        .o_tc          (o_tc),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare all outputs 1ns after the edge.
    task automatic step(input string tag, input int e_count, input int e_busy,
                        input int e_tc, input int e_done);
        @(posedge clk);
        #1;
        chk({tag, ".count"}, int'(o_count), e_count);
        chk({tag, ".busy"},  int'(o_busy),  e_busy);
        chk({tag, ".tc"},    int'(o_tc),    e_tc);
        chk({tag, ".done"},  int'(o_done),  e_done);
        $display("%0t %s: count=%0d busy=%0d tc=%0d done=%0d",
                 $time, tag, o_count, o_busy, o_tc, o_done);
    endtask

    task automatic drive(input logic ld, input int val, input logic st,
                         input logic sp, input logic ar);
        i_load        = ld;
        i_load_val    = WIDTH'(val);
        i_start       = st;
        i_stop        = sp;
        i_auto_reload = ar;
    endtask

    // Hand-computed expected counts for the auto-reload run after start (reload 2).
    int t3_cnt [7] = '{1, 0, 2, 1, 0, 2, 1};
    int t3_tc  [7] = '{0, 1, 0, 0, 1, 0, 0};

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        drive(0, 0, 0, 0, 0);
        #3;
        chk("rst0.count", int'(o_count), 0);
        chk("rst0.busy",  int'(o_busy),  0);
        chk("rst0.tc",    int'(o_tc),    0);
        chk("rst0.done",  int'(o_done),  0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: asynchronous reset mid-run.
        drive(1, 5, 0, 0, 0); step("t1_load", 5, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t1_start", 5, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t1_async.count", int'(o_count), 0);
        chk("t1_async.busy",  int'(o_busy),  0);
        chk("t1_async.tc",    int'(o_tc),    0);
        chk("t1_async.done",  int'(o_done),  0);
        $display("%0t t1_async: count=%0d busy=%0d", $time, o_count, o_busy);
        @(posedge clk); #1;
        rst = 1'b0;

        // T2: one-shot from 3.
        drive(1, 3, 0, 0, 0); step("t2_load", 3, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t2_start", 3, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        step("t2_c2", 2, 1, 0, 0);
        step("t2_c1", 1, 1, 0, 0);
        step("t2_c0", 0, 0, 1, 1);
        step("t2_hold", 0, 0, 0, 1);

        // T3: auto-reload with reload 2, period 3.
        drive(1, 2, 0, 0, 1); step("t3_load", 2, 0, 0, 0);
        drive(0, 0, 1, 0, 1); step("t3_start", 2, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            step($sformatf("t3_c%0d", k), t3_cnt[k], 1, t3_tc[k], 0);
        end

        // T4: pause at 6 and resume, one-shot.
        drive(1, 9, 0, 0, 0); step("t4_load", 9, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t4_start", 9, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        step("t4_c8", 8, 1, 0, 0);
        step("t4_c7", 7, 1, 0, 0);
        step("t4_c6", 6, 1, 0, 0);
        drive(0, 0, 0, 1, 0); step("t4_stop", 6, 0, 0, 0);
        drive(0, 0, 0, 0, 0); step("t4_held", 6, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t4_resume", 6, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int v = 5; v >= 1; v--) begin
            step($sformatf("t4_c%0d", v), v, 1, 0, 0);
        end
        step("t4_c0", 0, 0, 1, 1);

        // T5: load beats start+stop; stop at 1 suppresses tc.
        drive(1, 7, 1, 1, 0); step("t5_load_pri", 7, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t5_start", 7, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int v = 6; v >= 1; v--) begin
            step($sformatf("t5_c%0d", v), v, 1, 0, 0);
        end
        drive(0, 0, 0, 1, 0); step("t5_stop_at1", 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0); step("t5_held1", 1, 0, 0, 0);

        // T6: zero load cases.
        drive(1, 0, 0, 0, 0); step("t6_load0", 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0); step("t6_start0", 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0); step("t6_idle_done", 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0); step("t6_restart0", 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0); step("t6_after", 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
